// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)* =" expressions, with '*' binding tighter than '+'.
// Each '=' produces a one-cycle result pulse carrying either the value or an error flag.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM  = 3'd1,
    S_ADD  = 3'd2,
    S_MUL  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  state_t       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] prod_q, prod_d;
  logic [W-1:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  logic         is_digit, is_add, is_mul, is_eq;
  logic [3:0]   dig;
  logic [W-1:0] dig_w;
  logic [W-1:0] sum_add;
  logic [W-1:0] prod_mul;

  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_add   = (in == CH_ADD);
  assign is_mul   = (in == CH_MUL);
  assign is_eq    = (in == CH_EQ);
  assign dig      = in[3:0];
  assign dig_w    = {{(W-4){1'b0}}, dig};

  // W x 4 product truncated to W bits; overflow wraps silently.
  assign sum_add  = sum_q + prod_q;
  assign prod_mul = prod_q * dig_w;

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    prod_d         = prod_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            sum_d   = '0;
            prod_d  = dig_w;
            state_d = S_NUM;
          end else if (is_eq) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_add) begin
            sum_d   = sum_add;
            state_d = S_ADD;
          end else if (is_mul) begin
            state_d = S_MUL;
          end else if (is_eq) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ADD: begin
          if (is_digit) begin
            prod_d  = dig_w;
            state_d = S_NUM;
          end else if (is_eq) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_MUL: begin
          if (is_digit) begin
            prod_d  = prod_mul;
            state_d = S_NUM;
          end else if (is_eq) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          state_d = is_eq ? S_IDLE : S_ERR;
        end
        default: state_d = S_IDLE;
      endcase

      // Every '=' terminates the expression; only NUM holds a complete value.
      if (is_eq) begin
        result_valid_d = 1'b1;
        sum_d          = '0;
        prod_d         = '0;
        if (state_q == S_NUM) begin
          result_d = sum_add;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= S_IDLE;
      sum_q          <= '0;
      prod_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      prod_q         <= prod_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: a W=16 and a W=8 instance share one character stream.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in;
  logic [15:0] result;
  logic        result_valid, err, busy;
  logic [7:0]  result8;
  logic        result_valid8, err8, busy8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  expr_eval #(.W(16)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .result(result), .result_valid(result_valid), .err(err), .busy(busy)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .result(result8), .result_valid(result_valid8), .err(err8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one character for one cycle; sample 1 time unit after the edge.
  task automatic send(input byte c);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b1; in = c;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0; in = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in = "7";
    @(posedge clk); #1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
  endtask

  // Stream all but the last char of s expecting no pulse, then the last expecting one.
  task automatic run_expr(input string tag, input string s,
                          input logic [15:0] exp_res, input logic exp_err);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (i < s.len() - 1) chk({tag, " no pulse"}, 32'(result_valid), 32'd0);
    end
    chk({tag, " valid"},  32'(result_valid), 32'd1);
    chk({tag, " err"},    32'(err), 32'(exp_err));
    chk({tag, " result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset result", 32'(result), 32'd0);
    chk("reset valid",  32'(result_valid), 32'd0);
    chk("reset err",    32'(err), 32'd0);
    chk("reset busy",   32'(busy), 32'd0);

    // clr wins over a valid digit in the same cycle
    do_clr();
    chk("clr wins busy", 32'(busy), 32'd0);

    send("1");
    chk("busy after digit", 32'(busy), 32'd1);
    send("+"); send("2"); send("*"); send("3");
    chk("1+2*3 no early pulse", 32'(result_valid), 32'd0);
    send("=");
    chk("1+2*3 valid",  32'(result_valid), 32'd1);
    chk("1+2*3 result", 32'(result), 32'd7);
    chk("1+2*3 err",    32'(err), 32'd0);
    chk("1+2*3 busy",   32'(busy), 32'd0);
    gap();
    chk("pulse one cycle", 32'(result_valid), 32'd0);
    chk("result holds",    32'(result), 32'd7);

    // gapped stream: idle cycles must not advance or disturb state
    send("2"); gap(); gap();
    chk("gap busy", 32'(busy), 32'd1);
    send("*"); gap(); send("3"); gap(); send("*"); gap();
    send("4"); gap(); send("+"); gap(); send("1"); gap();
    chk("gap no pulse", 32'(result_valid), 32'd0);
    send("=");
    chk("gap valid",  32'(result_valid), 32'd1);
    chk("gap result", 32'(result), 32'd25);
    chk("gap err",    32'(err), 32'd0);
    gap();

    run_expr("+1=",  "+1=",  16'd0, 1'b1);
    run_expr("12=",  "12=",  16'd0, 1'b1);
    run_expr("1+=",  "1+=",  16'd0, 1'b1);
    run_expr("1-2=", "1-2=", 16'd0, 1'b1);
    run_expr("=",    "=",    16'd0, 1'b1);
    gap();
    chk("err clears", 32'(err), 32'd0);
    run_expr("space", "1 +2=", 16'd0, 1'b1);
    gap();

    // 9^5 = 59049; modulo 256 it is 169
    run_expr("9^5 w16", "9*9*9*9*9=", 16'd59049, 1'b0);
    chk("9^5 w8 valid",  32'(result_valid8), 32'd1);
    chk("9^5 w8 result", 32'(result8), 32'd169);
    chk("9^5 w8 err",    32'(err8), 32'd0);
    gap();

    // abort mid-expression
    send("1"); send("+"); send("2");
    do_clr();
    chk("clr no pulse",  32'(result_valid), 32'd0);
    chk("clr busy",      32'(busy), 32'd0);
    chk("clr result",    32'(result), 32'd0);
    gap();
    chk("after clr no pulse", 32'(result_valid), 32'd0);
    run_expr("3= after clr", "3=", 16'd3, 1'b0);

    // back-to-back expressions; result must hold between pulses
    run_expr("5=", "5=", 16'd5, 1'b0);
    send("4");
    chk("b2b hold valid", 32'(result_valid), 32'd0);
    chk("b2b hold result", 32'(result), 32'd5);
    chk("b2b busy", 32'(busy), 32'd1);
    send("*"); send("2");
    chk("b2b hold result2", 32'(result), 32'd5);
    send("=");
    chk("4*2 valid",  32'(result_valid), 32'd1);
    chk("4*2 result", 32'(result), 32'd8);
    chk("4*2 err",    32'(err), 32'd0);

    // 16-bit wrap: 9^5*9 = 531441 mod 65536 = 7153
    run_expr("wrap", "9*9*9*9*9*9=", 16'd7153, 1'b0);
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
